multicycle_control: RTL and testbench

Multi-cycle main control FSM for the MIPS datapath. It replaces single-cycle opcode decoding with a state sequence (fetch, decode, execute, memory, writeback) and drives every datapath enable and mux select from the current state. It also waits on a unified instruction/data memory through a ready handshake. It sits between the instruction register's opcode field and the shared ALU, register file, PC and memory.

---
 rtl/multicycle_control.sv | 150 +++++++++++++++
 tb/tb_multicycle_control.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS main control FSM driving datapath enables and mux selects from the current state
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  state_t state_q, state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end
  // Outputs are decoded only while out of reset, so an abort never leaks a write pulse.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    state_d     = FETCH;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          state_d = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          case (opcode)
            OP_R:         state_d = EXEC;
            OP_LW, OP_SW: state_d = MEMADR;
            OP_BEQ:       state_d = BRANCH;
            OP_J:         state_d = JUMP;
            OP_ADDI:      state_d = ADDIEX;
            default: begin
              illegal_op = 1'b1;
              instr_done = 1'b1;
              state_d    = FETCH;
            end
          endcase
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = opcode == OP_SW ? MEMWR : opcode == OP_LW ? MEMRD : FETCH;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          state_d = mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
          state_d    = mem_ready ? FETCH : MEMWR;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          state_d = ALUWB;
        end
        ALUWB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = ADDIWB;
        end
        ADDIWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end
  assign state = STATE_W'(state_q);
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven, directed and randomized checks of the multi-cycle control FSM
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic [17:0] ctrl;
  int tests = 0;
  int fails = 0;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                 RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  // Control word each state must present, straight from the per-state output list.
  function automatic logic [17:0] exp_ctrl(input int st, input logic [5:0] op, input logic rdy);
    logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, done, ill;
    logic [1:0] sb, aop, ps;
    {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, done, ill} = '0;
    {sb, aop, ps} = '0;
    case (st)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
      1:  begin sb = 2'b11; ill = !is_legal(op); done = ill; end
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin mw = 1; iord = 1; done = rdy; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; done = 1; end
      8:  begin sa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; done = 1; end
      9:  begin pw = 1; ps = 2'b10; done = 1; end
      10: begin sa = 1; sb = 2'b10; end
      11: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, done, ill};
  endfunction

  // Runs one instruction from FETCH; fw/mw = low cycles in FETCH / memory states, -1 = random.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           output int cyc, output int rw_n, output int mw_n,
                           output int done_n, output int ill_n, output int irw_n);
    int seq[$];
    cyc = 0; rw_n = 0; mw_n = 0; done_n = 0; ill_n = 0; irw_n = 0;
    opcode = op;
    case (op)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b001000: seq = '{0, 1, 10, 11};
      6'b000100: seq = '{0, 1, 8};
      6'b000010: seq = '{0, 1, 9};
      default:   seq = '{0, 1};
    endcase
    foreach (seq[i]) begin
      int lows;
      int w;
      logic waits_on_mem;
      waits_on_mem = seq[i] inside {0, 3, 5};
      w = (seq[i] == 0) ? fw : mw;
      lows = !waits_on_mem ? 0 : (w >= 0) ? w :
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      for (int k = 0; k <= lows; k++) begin
        logic r;
        r = waits_on_mem ? (k == lows) : 1'($urandom_range(0, 1));
        mem_ready = r;
        @(negedge clk);
        check($sformatf("st%0d_state", seq[i]), 32'(state), 32'(seq[i]));
        check($sformatf("st%0d_ctrl", seq[i]), 32'(ctrl), 32'(exp_ctrl(seq[i], op, r)));
        check("mutex", 32'((MemRead & MemWrite) | (RegWrite & MemWrite)), 32'd0);
        cyc++;
        rw_n += int'(RegWrite);
        mw_n += int'(MemWrite);
        done_n += int'(instr_done);
        ill_n += int'(illegal_op);
        irw_n += int'(IRWrite);
        @(posedge clk);
        #1;
      end
    end
  endtask

  typedef struct {
    logic [5:0] op;
    int lat;
    int rw;
    int mw;
    int ill;
  } vec_t;

  initial begin
    vec_t v[7];
    int cyc, rw_n, mw_n, done_n, ill_n, irw_n, tot;
    logic [5:0] legal[6];
    v[0] = '{6'b100011, 5, 1, 0, 0};
    v[1] = '{6'b101011, 4, 0, 1, 0};
    v[2] = '{6'b000000, 4, 1, 0, 0};
    v[3] = '{6'b001000, 4, 1, 0, 0};
    v[4] = '{6'b000100, 3, 0, 0, 0};
    v[5] = '{6'b000010, 3, 0, 0, 0};
    v[6] = '{6'b111111, 2, 0, 0, 1};
    legal = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
    mem_ready = 1'b1;
    #12;
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctrl", 32'(ctrl), 32'd0);
    mem_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    foreach (v[i]) begin
      run_instr(v[i].op, 0, 0, cyc, rw_n, mw_n, done_n, ill_n, irw_n);
      check($sformatf("lat_op%0h", v[i].op), 32'(cyc), 32'(v[i].lat));
      check($sformatf("regwr_op%0h", v[i].op), 32'(rw_n), 32'(v[i].rw));
      check($sformatf("memwr_op%0h", v[i].op), 32'(mw_n), 32'(v[i].mw));
      check($sformatf("done_op%0h", v[i].op), 32'(done_n), 32'd1);
      check($sformatf("ill_op%0h", v[i].op), 32'(ill_n), 32'(v[i].ill));
    end
    run_instr(6'b101011, 0, 3, cyc, rw_n, mw_n, done_n, ill_n, irw_n);
    check("sw_wait_lat", 32'(cyc), 32'd7);
    check("sw_wait_memwr", 32'(mw_n), 32'd4);
    check("sw_wait_done", 32'(done_n), 32'd1);
    run_instr(6'b000000, 0, 0, cyc, rw_n, mw_n, done_n, ill_n, irw_n);
    tot = cyc;
    run_instr(6'b000100, 0, 0, cyc, rw_n, mw_n, done_n, ill_n, irw_n);
    check("r_beq_total", 32'(tot + cyc), 32'd7);
    run_instr(6'b000010, 2, 0, cyc, rw_n, mw_n, done_n, ill_n, irw_n);
    check("fetch_wait_lat", 32'(cyc), 32'd5);
    check("fetch_wait_irw", 32'(irw_n), 32'd1);
    opcode = 6'b001000;
    mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("addi_in_exec", 32'(state), 32'd10);
    rst_n = 1'b0;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_ctrl", 32'(ctrl), 32'd0);
    @(negedge clk);
    check("abort_hold_ctrl", 32'(ctrl), 32'd0);
    mem_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_instr(6'b001000, 0, 0, cyc, rw_n, mw_n, done_n, ill_n, irw_n);
    check("post_abort_lat", 32'(cyc), 32'd4);
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : legal[$urandom_range(0, 5)];
      run_instr(op, -1, -1, cyc, rw_n, mw_n, done_n, ill_n, irw_n);
      check("rand_done", 32'(done_n), 32'd1);
      check("rand_irw", 32'(irw_n), 32'd1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
